// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared pointer-width helper, default depth and threshold levels for sync_fifo.
package sync_fifo_pkg;
  localparam int DEF_ASIZE    = 4;
  localparam int DEPTH        = 2**DEF_ASIZE;
  localparam int DEF_AE_LEVEL = 2;

  function automatic int ptr_w(input int asize);
    return asize + 1;
  endfunction

  function automatic int af_default(input int asize);
    return 2**asize - 2;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port array, synchronous write; read port registered by default,
// combinational when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [ASIZE-1:0] i_wr_addr,
  input  logic [DSIZE-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [ASIZE-1:0] i_rd_addr,
  output logic [DSIZE-1:0] o_rd_data
);
  logic [DSIZE-1:0] r_mem [2**ASIZE];

  always_ff @(posedge clk)
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rd_data = r_mem[i_rd_addr];
`else
  logic [DSIZE-1:0] r_rd_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];

  assign o_rd_data = r_rd_data;
`endif
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count, almost/full/empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = DEF_ASIZE,
  parameter int AF_LEVEL = af_default(ASIZE),
  parameter int AE_LEVEL = DEF_AE_LEVEL
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = ptr_w(ASIZE);
  localparam logic [PW-1:0] AF = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE = PW'(AE_LEVEL);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_count;
  logic          r_overflow, r_underflow;
  logic          w_full, w_empty, w_wr_acc, w_rd_acc;

  // The wrap bit tells a full buffer (MSBs differ) from an empty one (pointers equal).
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (r_wr_ptr[ASIZE] != r_rd_ptr[ASIZE]) &&
                     (r_wr_ptr[ASIZE-1:0] == r_rd_ptr[ASIZE-1:0]);
  assign w_empty   = r_wr_ptr == r_rd_ptr;
  assign w_wr_acc  = wr_en && !w_full;
  assign w_rd_acc  = rd_en && !w_empty;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (wr_en && w_full) r_overflow <= 1'b1;
      if (rd_en && w_empty) r_underflow <= 1'b1;
    end

  sync_fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_wr_acc),
    .i_wr_addr(r_wr_ptr[ASIZE-1:0]),
    .i_wr_data(wr_data),
    .i_rd_en  (w_rd_acc),
    .i_rd_addr(r_rd_ptr[ASIZE-1:0]),
    .o_rd_data(rd_data)
  );

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign almost_full  = w_count >= AF;
  assign almost_empty = w_count <= AE;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
endmodule
